// File: rtl/rr_arbiter_16.sv
// rr_arbiter_16: 16-way round-robin arbiter with registered one-hot grant.
// A grant is held while its owner keeps requesting, optionally capped by a
// hold limit. Arbitration searches upward from a fairness pointer that
// advances past each owner when its grant ends.
module rr_arbiter_16 #(
  parameter int MAX_HOLD = 64,
  parameter int CNT_W    = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_req,
  input  logic [15:0] i_mask,
  output logic [15:0] o_gnt,
  output logic [3:0]  o_gnt_idx,
  output logic        o_gnt_vld,
  output logic        o_preempt
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // A hold limit of zero disables preemption entirely.
  localparam bit               HOLD_EN  = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t             r_state;
  logic [3:0]         r_ptr;
  logic [CNT_W-1:0]   r_hold_cnt;
  logic [15:0]        r_gnt;
  logic [3:0]         r_gnt_idx;
  logic               r_gnt_vld;
  logic               r_preempt;

  logic [15:0]        w_elig;
  logic [15:0]        w_rot;
  logic [3:0]         w_enc;
  logic               w_any;
  logic [3:0]         w_win;
  logic [15:0]        w_win_onehot;
  logic               w_owner_req;
  logic               w_hold_hit;
  logic [CNT_W-1:0]   w_cnt_next;

  assign w_elig = i_req & i_mask;
  assign w_any  = |w_elig;

  // Rotate the eligible vector so that the pointer position lands on bit 0.
  always_comb begin
    w_rot = '0;
    for (int i = 0; i < 16; i++) begin
      w_rot[i] = w_elig[4'(i) + r_ptr];
    end
  end

  // Lowest-index-first encoder over the rotated vector; zero when nothing set.
  always_comb begin
    w_enc = '0;
    for (int i = 15; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_enc = 4'(i);
      end
    end
  end

  // Undo the rotation; the 4-bit add wraps 15 -> 0 naturally.
  assign w_win        = w_enc + r_ptr;
  assign w_win_onehot = 16'h0001 << w_win;

  assign w_owner_req = i_req[r_gnt_idx];
  assign w_hold_hit  = HOLD_EN && (r_hold_cnt == HOLD_LIM);
  assign w_cnt_next  = (r_hold_cnt == CNT_MAX) ? r_hold_cnt : r_hold_cnt + CNT_W'(1);

  // Arbitration FSM: every output is a flop updated here.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_hold_cnt <= '0;
      r_gnt      <= '0;
      r_gnt_idx  <= '0;
      r_gnt_vld  <= 1'b0;
      r_preempt  <= 1'b0;
    end else begin
      r_preempt <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_state    <= BUSY;
            r_gnt      <= w_win_onehot;
            r_gnt_idx  <= w_win;
            r_gnt_vld  <= 1'b1;
            r_hold_cnt <= CNT_W'(1);
          end
        end
        BUSY: begin
          if (!w_owner_req || w_hold_hit) begin
            r_state    <= IDLE;
            r_gnt      <= '0;
            r_gnt_idx  <= '0;
            r_gnt_vld  <= 1'b0;
            r_hold_cnt <= '0;
            r_ptr      <= r_gnt_idx + 4'd1;
            r_preempt  <= w_owner_req;
          end else begin
            r_hold_cnt <= w_cnt_next;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_gnt      <= '0;
          r_gnt_idx  <= '0;
          r_gnt_vld  <= 1'b0;
          r_hold_cnt <= '0;
        end
      endcase
    end
  end

  assign o_gnt     = r_gnt;
  assign o_gnt_idx = r_gnt_idx;
  assign o_gnt_vld = r_gnt_vld;
  assign o_preempt = r_preempt;

endmodule

// File: tb/tb_rr_arbiter_16.sv
// tb_rr_arbiter_16: directed vector table on a hold-limit-4 arbiter plus a
// rotation sequence on a hold-limit-1 arbiter sharing the same stimulus.
module tb_rr_arbiter_16;

  typedef struct {
    logic        rst;
    logic [15:0] req;
    logic [15:0] mask;
    logic [15:0] gnt;
    logic [3:0]  idx;
    logic        vld;
    logic        pre;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic [15:0] mask;

  logic [15:0] gntA;
  logic [3:0]  idxA;
  logic        vldA;
  logic        preA;
  logic [15:0] gntB;
  logic [3:0]  idxB;
  logic        vldB;
  logic        preB;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  rr_arbiter_16 #(.MAX_HOLD(4), .CNT_W(16)) u_dutA (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_mask(mask),
    .o_gnt(gntA), .o_gnt_idx(idxA), .o_gnt_vld(vldA), .o_preempt(preA)
  );

  rr_arbiter_16 #(.MAX_HOLD(1), .CNT_W(16)) u_dutB (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_mask(mask),
    .o_gnt(gntB), .o_gnt_idx(idxB), .o_gnt_vld(vldB), .o_preempt(preB)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic addVec(input logic r, input logic [15:0] rq, input logic [15:0] mk,
                        input logic [15:0] g, input logic [3:0] ix, input logic v, input logic p);
    vec_t t;
    t.rst = r; t.req = rq; t.mask = mk; t.gnt = g; t.idx = ix; t.vld = v; t.pre = p;
    vecs.push_back(t);
  endtask

  // Drive inputs, then sample 1 time unit after the rising edge.
  task automatic applyStimulus(input logic r, input logic [15:0] rq, input logic [15:0] mk);
    rst  = r;
    req  = rq;
    mask = mk;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Structural consistency: one-hot-or-zero grant, matching index and valid.
  task automatic checkShape(input string name, input logic [15:0] g, input logic [3:0] ix, input logic v);
    logic [15:0] fromIdx;
    fromIdx = (g != 16'h0) ? (16'h0001 << ix) : 16'h0;
    checkOutput({name, " onehot"}, 16'($onehot0(g)), 16'h1);
    checkOutput({name, " idx-gnt"}, g, fromIdx);
    checkOutput({name, " idx-zero"}, 16'((g == 16'h0) ? ix : 4'd0), 16'h0);
    checkOutput({name, " vld"}, 16'(v), 16'(g != 16'h0));
  endtask

  initial begin
    logic [15:0] expG;
    string nm;
    rst  = 1'b1;
    req  = '0;
    mask = 16'hFFFF;

    //       rst   req       mask      gnt       idx  vld  pre
    addVec(1'b1, 16'h0000, 16'hFFFF, 16'h0000, 4'd0,  0, 0); // reset
    addVec(1'b0, 16'h0000, 16'hFFFF, 16'h0000, 4'd0,  0, 0); // idle
    addVec(1'b0, 16'h0010, 16'hFFFF, 16'h0010, 4'd4,  1, 0); // single req
    addVec(1'b0, 16'h0000, 16'hFFFF, 16'h0000, 4'd0,  0, 0); // release, ptr=5
    addVec(1'b0, 16'h0204, 16'hFFFF, 16'h0200, 4'd9,  1, 0); // ptr5 {2,9} -> 9
    addVec(1'b0, 16'h0000, 16'hFFFF, 16'h0000, 4'd0,  0, 0); // ptr=10
    addVec(1'b0, 16'h2000, 16'hFFFF, 16'h2000, 4'd13, 1, 0); // grant 13
    addVec(1'b0, 16'h0000, 16'hFFFF, 16'h0000, 4'd0,  0, 0); // ptr=14
    addVec(1'b0, 16'h0005, 16'hFFFF, 16'h0001, 4'd0,  1, 0); // wrap -> 0
    addVec(1'b0, 16'h0004, 16'hFFFF, 16'h0000, 4'd0,  0, 0); // release, ptr=1
    addVec(1'b0, 16'h0005, 16'hFFFF, 16'h0004, 4'd2,  1, 0); // ptr1 -> 2
    addVec(1'b0, 16'h0000, 16'hFFFF, 16'h0000, 4'd0,  0, 0); // ptr=3
    addVec(1'b0, 16'h0003, 16'hFFFE, 16'h0002, 4'd1,  1, 0); // mask hides 0
    addVec(1'b0, 16'h0003, 16'h0000, 16'h0002, 4'd1,  1, 0); // mask off, held
    addVec(1'b0, 16'h0003, 16'h0000, 16'h0002, 4'd1,  1, 0);
    addVec(1'b0, 16'h0001, 16'h0000, 16'h0000, 4'd0,  0, 0); // release, ptr=2
    addVec(1'b0, 16'h0001, 16'h0000, 16'h0000, 4'd0,  0, 0); // masked, stays idle
    addVec(1'b0, 16'h8000, 16'hFFFF, 16'h8000, 4'd15, 1, 0); // grant 15
    addVec(1'b1, 16'h8000, 16'hFFFF, 16'h0000, 4'd0,  0, 0); // reset mid-grant
    addVec(1'b0, 16'h8001, 16'hFFFF, 16'h0001, 4'd0,  1, 0); // ptr back to 0
    addVec(1'b0, 16'h0000, 16'hFFFF, 16'h0000, 4'd0,  0, 0); // ptr=1
    addVec(1'b0, 16'h0100, 16'hFFFF, 16'h0100, 4'd8,  1, 0); // hold cnt 1
    addVec(1'b0, 16'h0100, 16'hFFFF, 16'h0100, 4'd8,  1, 0); // 2
    addVec(1'b0, 16'h0100, 16'hFFFF, 16'h0100, 4'd8,  1, 0); // 3
    addVec(1'b0, 16'h0100, 16'hFFFF, 16'h0100, 4'd8,  1, 0); // 4
    addVec(1'b0, 16'h0100, 16'hFFFF, 16'h0000, 4'd0,  0, 1); // preempt, ptr=9
    addVec(1'b0, 16'h0100, 16'hFFFF, 16'h0100, 4'd8,  1, 0); // re-grant 8
    addVec(1'b0, 16'h0000, 16'hFFFF, 16'h0000, 4'd0,  0, 0); // release, ptr=9
    addVec(1'b0, 16'h0101, 16'hFFFF, 16'h0001, 4'd0,  1, 0); // ptr9 {0,8} -> 0
    addVec(1'b0, 16'h0101, 16'hFFFF, 16'h0001, 4'd0,  1, 0);
    addVec(1'b0, 16'h0101, 16'hFFFF, 16'h0001, 4'd0,  1, 0);
    addVec(1'b0, 16'h0101, 16'hFFFF, 16'h0001, 4'd0,  1, 0);
    addVec(1'b0, 16'h0101, 16'hFFFF, 16'h0000, 4'd0,  0, 1); // preempt, ptr=1
    addVec(1'b0, 16'h0101, 16'hFFFF, 16'h0100, 4'd8,  1, 0); // 8 beats 0 now
    addVec(1'b0, 16'h0000, 16'hFFFF, 16'h0000, 4'd0,  0, 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].req, vecs[i].mask);
      nm = $sformatf("vec%0d", i);
      checkOutput({nm, " gnt"}, gntA, vecs[i].gnt);
      checkOutput({nm, " idx"}, 16'(idxA), 16'(vecs[i].idx));
      checkOutput({nm, " vld"}, 16'(vldA), 16'(vecs[i].vld));
      checkOutput({nm, " preempt"}, 16'(preA), 16'(vecs[i].pre));
      checkShape(nm, gntA, idxA, vldA);
    end

    // Rotation with hold limit 1: ascending grants, each ended by a preempt.
    applyStimulus(1'b1, 16'h0000, 16'hFFFF);
    checkOutput("rot reset gnt", gntB, 16'h0000);
    checkOutput("rot reset preempt", 16'(preB), 16'h0);
    for (int k = 0; k < 17; k++) begin
      expG = 16'h0001 << (k % 16);
      applyStimulus(1'b0, 16'hFFFF, 16'hFFFF);
      nm = $sformatf("rot%0d", k);
      checkOutput({nm, " gnt"}, gntB, expG);
      checkOutput({nm, " idx"}, 16'(idxB), 16'(k % 16));
      checkOutput({nm, " preempt-low"}, 16'(preB), 16'h0);
      checkShape(nm, gntB, idxB, vldB);
      applyStimulus(1'b0, 16'hFFFF, 16'hFFFF);
      checkOutput({nm, " bubble gnt"}, gntB, 16'h0000);
      checkOutput({nm, " bubble preempt"}, 16'(preB), 16'h1);
    end

    // Reset during a preempt bubble clears the pulse and the pointer.
    applyStimulus(1'b1, 16'hFFFF, 16'hFFFF);
    checkOutput("rstpre gnt", gntB, 16'h0000);
    checkOutput("rstpre preempt", 16'(preB), 16'h0);
    applyStimulus(1'b0, 16'h8001, 16'hFFFF);
    checkOutput("rstpre regrant", gntB, 16'h0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_16.md
Name: rr_arbiter_16

Overview:
- Round-robin arbiter that shares one resource among 16 requesters (e.g. one SRAM write port among 16 ingress ports).
- Produces a registered one-hot grant plus its 4-bit index, using the same lowest-index-first search as the 16-to-4 select decoder, rotated by a fairness pointer.
- A grant is held while the owner keeps its request asserted. An optional hold limit preempts long owners.

Parameters:
- MAX_HOLD, 64: maximum consecutive cycles a grant may be held. 0 means unlimited. Legal range 0..65535.
- CNT_W, 16: hold counter width. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  16  request per requester; held high for as long as access is wanted.
- mask  input  16  1 = requester eligible; 0 = ignored for new arbitration.
- gnt  output  16  one-hot registered grant; all-zero when idle.
- gnt_idx  output  4  index of granted requester; 0 when gnt_vld=0.
- gnt_vld  output  1  1 while a grant is active (equals OR of gnt).
- preempt  output  1  one-cycle pulse in the cycle a grant is removed by the hold limit.

Behaviour:
- Reset: synchronous, active-high, sampled on clk rising edge.
  - All outputs reset to 0.
  - State = IDLE, ptr = 0, hold_cnt = 0.
  - Reset asserted mid-grant drops gnt in the next cycle. No preempt pulse is generated.
- Eligible vector: elig = req & mask.
- IDLE state:
  - If elig == 0, remain in IDLE with outputs 0.
  - Otherwise the winner is the first set bit of elig searching upward from ptr, wrapping 15 -> 0. Example: ptr=5, elig bits {2,9} gives winner 9.
  - On the next edge: state = BUSY, gnt = 1<<winner, gnt_idx = winner, gnt_vld = 1, hold_cnt = 1.
  - Latency from req rising to gnt = 1 cycle.
- BUSY state (owner = gnt_idx):
  - Release: if req[owner]==0 at an edge, go to IDLE with gnt = 0 and ptr = (owner+1) mod 16.
  - Hold limit: else if MAX_HOLD != 0 and hold_cnt == MAX_HOLD, go to IDLE with gnt = 0, ptr = (owner+1) mod 16, and preempt = 1 for exactly that one cycle. The owner may re-request; it is re-arbitrated normally.
  - Otherwise stay in BUSY with hold_cnt incremented. The counter saturates and never wraps when MAX_HOLD = 0.
  - mask changes while in BUSY do not revoke the current grant. mask affects only new arbitration.
- Exactly one bubble cycle (gnt = 0) always separates consecutive grants. Back-to-back ownership changes therefore take 2 cycles per grant.
- ptr changes only on grant release or preempt. It does not change on reset release or while idle with no requests.
- Fairness: with all 16 requesting continuously, each requester is granted exactly once per 16 grants, in ascending order.
- gnt is always one-hot or zero. gnt_idx is consistent with gnt in every cycle.
- All outputs come from flops. No combinational path from req to gnt.
- Encoder output is never X. Defaults are assigned on all paths.

Test Plan:
- Reset then single request: req=0x0010 -> gnt=0x0010, gnt_idx=4, gnt_vld=1 one cycle later. Drop req -> gnt=0 next cycle, ptr=5.
- Rotation: req=0xFFFF held (MAX_HOLD=1) -> grants 0,1,2,...,15,0 with one idle cycle between each. preempt pulses on each removal.
- Wrap search: ptr=14 (after granting 13), req=0x0005 -> winner 0. After release, ptr=1; with req still 0x0005 the next winner is 2.
- Hold limit: MAX_HOLD=4, req=0x0100 held -> gnt_vld high exactly 4 cycles, preempt=1 in the 5th cycle with gnt=0, re-grant to 8 in the 6th cycle.
- Mask: req=0x0003, mask=0xFFFE -> grant 1 only. Set mask=0x0000 while 1 is granted -> grant persists until req[1] drops, then IDLE with no new grant.
- Reset mid-grant: assert rst while gnt=0x8000 -> next cycle all outputs 0, preempt=0. After rst is released with req=0x8001 -> winner 0 (ptr reset to 0).
